// File: rtl/stack_reader.sv
// Drains the byte stack on a start request, sending each popped byte
// (LIFO order) as an 8N1 frame on txd with BIT_CYCLES clocks per bit.
module stack_reader #(
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic [7:0] stk_dout,
    input  logic       stk_empty,
    output logic       pop,
    output logic       txd,
    output logic       busy,
    output logic       done,
    output logic [3:0] nread
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [7:0] BIT_LAST = 8'(BIT_CYCLES - 1);

    logic [2:0] state;
    logic       start_prev;
    logic [7:0] shreg;
    logic [7:0] bit_timer;
    logic [2:0] bit_idx;
    logic       start_pulse;
    logic       bit_end;

    assign start_pulse = start_btn & ~start_prev;
    assign bit_end     = (bit_timer == 8'd0);

    // Pop is gated by the live empty flag so it can never fire on an empty stack.
    assign pop  = (state == S_CHECK) && !stk_empty;
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // NOTE: all state moves on the falling edge; non-blocking assignments keep
    // every register reading pre-edge values regardless of statement order.
    always_ff @(negedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            start_prev <= 1'b0;
            shreg      <= 8'd0;
            bit_timer  <= 8'd0;
            bit_idx    <= 3'd0;
            txd        <= 1'b1;
            nread      <= 4'd0;
        end else begin
            start_prev <= start_btn;
            case (state)
                S_IDLE: begin
                    if (start_pulse) begin
                        state <= S_CHECK;
                        nread <= 4'd0;
                    end
                end
                S_CHECK: begin
                    if (stk_empty) begin
                        state <= S_DONE;
                    end else begin
                        shreg     <= stk_dout;
                        bit_timer <= BIT_LAST;
                        txd       <= 1'b0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_timer <= BIT_LAST;
                        bit_idx   <= 3'd0;
                        txd       <= shreg[0];
                        state     <= S_DATA;
                    end else begin
                        bit_timer <= bit_timer - 8'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_timer <= BIT_LAST;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            // shreg[1] is the next bit to appear once shreg shifts down.
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            txd     <= shreg[1];
                        end
                    end else begin
                        bit_timer <= bit_timer - 8'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (nread != 4'd8) begin
                            nread <= nread + 4'd1;
                        end
                        state <= S_CHECK;
                    end else begin
                        bit_timer <= bit_timer - 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_reader.sv
// Directed bench for stack_reader: two instances (BIT_CYCLES 4 and 1), each
// with a behavioural push/pop stack; frames are decoded by bit-time sampling.
module tb_stack_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start4, start1;
    logic       push4, push1;
    logic [7:0] pdata4, pdata1;

    logic [7:0] dout4, dout1;
    logic       empty4, empty1;
    logic       pop4, pop1, txd4, txd1, busy4, busy1, done4, done1;
    logic [3:0] nread4, nread1;

    logic [7:0] mem4 [8];
    logic [7:0] mem1 [8];
    logic [3:0] sp4 = 4'd0;
    logic [3:0] sp1 = 4'd0;

    int cyc = 0;
    int bad4 = 0, bad1 = 0;
    int donecnt4 = 0, donecnt1 = 0;
    int pop_t4[$];
    int pop_t1[$];

    int n_tests = 0;
    int n_fail  = 0;

    stack_reader #(.BIT_CYCLES(4)) u_dut4 (
        .clk(clk), .reset(reset), .start_btn(start4), .stk_dout(dout4),
        .stk_empty(empty4), .pop(pop4), .txd(txd4), .busy(busy4),
        .done(done4), .nread(nread4)
    );

    stack_reader #(.BIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start_btn(start1), .stk_dout(dout1),
        .stk_empty(empty1), .pop(pop1), .txd(txd1), .busy(busy1),
        .done(done1), .nread(nread1)
    );

    // Stack models: push from the bench, pop from the DUT, both on the falling edge.
    assign empty4 = (sp4 == 4'd0);
    assign empty1 = (sp1 == 4'd0);
    assign dout4  = empty4 ? 8'h00 : mem4[3'(sp4 - 4'd1)];
    assign dout1  = empty1 ? 8'h00 : mem1[3'(sp1 - 4'd1)];

    always @(negedge clk) begin
        if (push4) begin
            mem4[3'(sp4)] <= pdata4;
            sp4 <= sp4 + 4'd1;
        end else if (pop4 && sp4 != 4'd0) begin
            sp4 <= sp4 - 4'd1;
        end
        if (push1) begin
            mem1[3'(sp1)] <= pdata1;
            sp1 <= sp1 + 4'd1;
        end else if (pop1 && sp1 != 4'd0) begin
            sp1 <= sp1 - 4'd1;
        end
    end

    always @(posedge clk) begin
        if (pop4) pop_t4.push_back(cyc);
        if (pop1) pop_t1.push_back(cyc);
        if (pop4 && empty4) bad4 <= bad4 + 1;
        if (pop1 && empty1) bad1 <= bad1 + 1;
        if (done4) donecnt4 <= donecnt4 + 1;
        if (done1) donecnt1 <= donecnt1 + 1;
        cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input bit sel, input logic [7:0] d);
        if (sel) begin push1 = 1'b1; pdata1 = d; end
        else     begin push4 = 1'b1; pdata4 = d; end
        @(posedge clk);
        push1 = 1'b0;
        push4 = 1'b0;
    endtask

    task automatic wait_txd_low(input bit sel);
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            if ((sel ? txd1 : txd4) == 1'b0) found = 1'b1;
        end
        if (!found) check("start_bit_timeout", 32'd0, 32'd1);
    endtask

    // Returns at the last stop-bit cycle; samples each bit near its middle.
    task automatic recv(input bit sel, input int bc, output logic [7:0] b);
        b = 8'h00;
        wait_txd_low(sel);
        for (int c = 2; c <= 10 * bc; c++) begin
            @(posedge clk);
            for (int k = 0; k < 8; k++) begin
                if (c == bc * (k + 1) + 1 + (bc - 1) / 2) b[k] = sel ? txd1 : txd4;
            end
            if (c == 9 * bc + 1 + (bc - 1) / 2)
                check("stop_bit", 32'(sel ? txd1 : txd4), 32'd1);
        end
    endtask

    task automatic wait_done(input bit sel);
        bit found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(posedge clk);
            if ((sel ? done1 : done4) == 1'b1) found = 1'b1;
        end
        if (!found) check("done_timeout", 32'd0, 32'd1);
    endtask

    logic [7:0] rx;
    int n0, d0;

    initial begin
        reset  = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
        push4  = 1'b0;
        push1  = 1'b0;
        pdata4 = 8'h00;
        pdata1 = 8'h00;
        repeat (3) @(posedge clk);
        reset = 1'b1;

        // Idle after reset: {txd,pop,busy,done,nread}
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            check("reset_idle", 32'({txd4, pop4, busy4, done4, nread4}), 32'h80);
        end

        // Empty stack: CHECK then DONE, no pop
        start4 = 1'b1;
        @(posedge clk);
        check("empty_cyc1", 32'({busy4, pop4, done4}), 32'b100);
        @(posedge clk);
        check("empty_cyc2", 32'({busy4, pop4, done4}), 32'b101);
        check("empty_nread", 32'(nread4), 32'd0);
        @(posedge clk);
        check("empty_cyc3", 32'({busy4, pop4, done4}), 32'b000);
        start4 = 1'b0;
        repeat (2) @(posedge clk);

        // Two bytes, BIT_CYCLES=4
        push(1'b0, 8'hA5);
        push(1'b0, 8'h3C);
        n0 = pop_t4.size();
        d0 = donecnt4;
        start4 = 1'b1;
        recv(1'b0, 4, rx);
        check("two_byte0", 32'(rx), 32'h3C);
        recv(1'b0, 4, rx);
        check("two_byte1", 32'(rx), 32'hA5);
        wait_done(1'b0);
        check("two_nread", 32'(nread4), 32'd2);
        @(posedge clk);
        start4 = 1'b0;
        repeat (5) @(posedge clk);
        check("two_pops", 32'(pop_t4.size() - n0), 32'd2);
        if (pop_t4.size() - n0 >= 2)
            check("two_pop_gap", 32'(pop_t4[n0 + 1] - pop_t4[n0]), 32'd41);
        check("two_done_cnt", 32'(donecnt4 - d0), 32'd1);
        check("two_no_empty_pop", 32'(bad4), 32'd0);

        // Full stack of 8, BIT_CYCLES=1
        for (int i = 1; i <= 8; i++) push(1'b1, 8'(i));
        n0 = pop_t1.size();
        d0 = donecnt1;
        start1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            recv(1'b1, 1, rx);
            check($sformatf("full_byte%0d", k), 32'(rx), 32'(8 - k));
        end
        wait_done(1'b1);
        check("full_nread", 32'(nread1), 32'd8);
        start1 = 1'b0;
        repeat (5) @(posedge clk);
        check("full_pops", 32'(pop_t1.size() - n0), 32'd8);
        check("full_done_cnt", 32'(donecnt1 - d0), 32'd1);
        check("full_no_empty_pop", 32'(bad1), 32'd0);
        check("full_idle", 32'(busy1), 32'd0);

        // Start held high, extra edge mid-frame is dropped
        push(1'b0, 8'h11);
        push(1'b0, 8'h22);
        n0 = pop_t4.size();
        d0 = donecnt4;
        start4 = 1'b1;
        fork
            begin
                repeat (12) @(posedge clk);
                start4 = 1'b0;
                @(posedge clk);
                start4 = 1'b1;
            end
            begin
                recv(1'b0, 4, rx);
                check("held_byte0", 32'(rx), 32'h22);
            end
        join
        recv(1'b0, 4, rx);
        check("held_byte1", 32'(rx), 32'h11);
        wait_done(1'b0);
        repeat (100) @(posedge clk);
        check("held_pops", 32'(pop_t4.size() - n0), 32'd2);
        check("held_done_cnt", 32'(donecnt4 - d0), 32'd1);
        check("held_idle", 32'(busy4), 32'd0);
        check("held_nread", 32'(nread4), 32'd2);
        start4 = 1'b0;
        repeat (2) @(posedge clk);

        // Reset during data bit 3 of the first byte (0x55 bit3 = 0)
        push(1'b0, 8'h44);
        push(1'b0, 8'h55);
        start4 = 1'b1;
        wait_txd_low(1'b0);
        repeat (17) @(posedge clk);
        check("rst_bit3", 32'({busy4, txd4}), 32'b10);
        reset  = 1'b0;
        start4 = 1'b0;
        @(posedge clk);
        check("rst_abort", 32'({txd4, pop4, busy4, done4, nread4}), 32'h80);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        start4 = 1'b1;
        recv(1'b0, 4, rx);
        check("rst_resume_byte", 32'(rx), 32'h44);
        wait_done(1'b0);
        check("rst_resume_nread", 32'(nread4), 32'd1);
        start4 = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
